// File: rtl/flags_pkg.sv
// Shared definitions for the FLAGS controller: bit positions, software op
// encodings and the sequencing FSM states.
package flags_pkg;

  localparam int Z_B  = 0;
  localparam int N_B  = 1;
  localparam int C_B  = 2;
  localparam int V_B  = 3;
  localparam int IE_B = 4;

  localparam logic [15:0] RESERVED_MASK = 16'hFFE0;

  localparam logic [1:0] OP_SET  = 2'b00;
  localparam logic [1:0] OP_CLR  = 2'b01;
  localparam logic [1:0] OP_LOAD = 2'b10;
  localparam logic [1:0] OP_TGL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    SAVE_CLR,
    RESTORE_LD
  } state_e;

endpackage

// File: rtl/flags_stack.sv
// LIFO shadow stack holding saved FLAGS values so interrupt entries can nest.
// Entry contents are left unreset; only the pointer returns to empty.
module flags_stack
  import flags_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    ptr_q;
  logic [PW-1:0]    ptr_d;
  logic [PW-1:0]    ptr_m1;
  logic             do_push;
  logic             do_pop;

  assign full    = (ptr_q == PW'(DEPTH));
  assign empty   = (ptr_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty && !push;
  assign ptr_m1  = ptr_q - PW'(1);
  assign top     = mem_q[ptr_m1[AW-1:0]];

  always_comb begin
    ptr_d = ptr_q;
    if (do_push) begin
      ptr_d = ptr_q + PW'(1);
    end else if (do_pop) begin
      ptr_d = ptr_m1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[ptr_q[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/flags_ctrl.sv
// Owns the architectural FLAGS register and arbitrates ALU, software and
// interrupt save/restore updates (restore > save > software > ALU).
module flags_ctrl
  import flags_pkg::*;
#(
  parameter int FLAG_W      = 16,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              alu_req,
  input  logic [3:0]        alu_flags,
  input  logic [3:0]        alu_mask,
  output logic              alu_gnt,
  input  logic              sw_req,
  input  logic [1:0]        sw_op,
  input  logic [FLAG_W-1:0] sw_mask,
  input  logic [FLAG_W-1:0] sw_data,
  output logic              sw_gnt,
  input  logic              irq_save,
  input  logic              irq_restore,
  output logic              irq_done,
  output logic [FLAG_W-1:0] flags,
  output logic              stk_full,
  output logic              stk_empty,
  output logic              err
);

  // Only Z, N, C, V and IE exist; everything above reads as zero.
  localparam logic [FLAG_W-1:0] KEEP_MASK = FLAG_W'({(IE_B + 1){1'b1}});

  state_e            state_q, state_d;
  logic [FLAG_W-1:0] flags_q, flags_d;
  logic              flags_en;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic              push, pop;
  logic [FLAG_W-1:0] stk_top;
  logic              alu_gnt_c, sw_gnt_c;

  flags_stack #(
    .WIDTH (FLAG_W),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk   (clk),
    .rst_b (rst_b),
    .push  (push),
    .pop   (pop),
    .din   (flags_q),
    .top   (stk_top),
    .full  (stk_full),
    .empty (stk_empty)
  );

  always_comb begin
    state_d   = state_q;
    flags_d   = flags_q;
    flags_en  = 1'b0;
    err_d     = err_q;
    done_d    = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    alu_gnt_c = 1'b0;
    sw_gnt_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (irq_restore) begin
          if (stk_empty) begin
            err_d  = 1'b1;
            done_d = 1'b1;
          end else begin
            state_d = RESTORE_LD;
          end
        end else if (irq_save) begin
          // A save on a full stack still drops IE so the handler runs masked.
          if (stk_full) begin
            err_d = 1'b1;
          end else begin
            push = 1'b1;
          end
          state_d = SAVE_CLR;
        end else if (sw_req) begin
          sw_gnt_c = 1'b1;
          flags_en = 1'b1;
          case (sw_op)
            OP_SET:  flags_d = flags_q | sw_mask;
            OP_CLR:  flags_d = flags_q & ~sw_mask;
            OP_LOAD: flags_d = (flags_q & ~sw_mask) | (sw_data & sw_mask);
            OP_TGL:  flags_d = flags_q ^ sw_mask;
            default: flags_d = flags_q;
          endcase
        end else if (alu_req) begin
          alu_gnt_c = 1'b1;
          flags_en  = 1'b1;
          flags_d[V_B:Z_B] = (flags_q[V_B:Z_B] & ~alu_mask) | (alu_flags & alu_mask);
        end
      end
      SAVE_CLR: begin
        flags_d[IE_B] = 1'b0;
        flags_en      = 1'b1;
        done_d        = 1'b1;
        state_d       = IDLE;
      end
      RESTORE_LD: begin
        flags_d  = stk_top;
        flags_en = 1'b1;
        pop      = 1'b1;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    flags_d = flags_d & KEEP_MASK;
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q <= IDLE;
      flags_q <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      done_q  <= done_d;
      if (flags_en) begin
        flags_q <= flags_d;
      end
    end
  end

  assign alu_gnt  = alu_gnt_c && rst_b;
  assign sw_gnt   = sw_gnt_c && rst_b;
  assign irq_done = done_q;
  assign flags    = flags_q;
  assign err      = err_q;

endmodule

// File: tb/tb_flags_ctrl.sv
// Scoreboard bench for flags_ctrl: stimulus queues expected events, a monitor
// pops and compares whenever a grant or irq_done appears.
module tb_flags_ctrl;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        alu_req;
  logic [3:0]  alu_flags;
  logic [3:0]  alu_mask;
  logic        alu_gnt;
  logic        sw_req;
  logic [1:0]  sw_op;
  logic [15:0] sw_mask;
  logic [15:0] sw_data;
  logic        sw_gnt;
  logic        irq_save;
  logic        irq_restore;
  logic        irq_done;
  logic [15:0] flags;
  logic        stk_full;
  logic        stk_empty;
  logic        err;

  typedef struct {
    string       name;
    logic [2:0]  evt;
    logic [15:0] flags;
    logic        full;
    logic        empty;
    logic        err;
  } exp_t;

  exp_t sbQ[$];
  int   compared   = 0;
  int   mismatched = 0;

  flags_ctrl #(.FLAG_W(16), .STACK_DEPTH(4)) dut (
    .clk         (clk),
    .rst_b       (rst_b),
    .alu_req     (alu_req),
    .alu_flags   (alu_flags),
    .alu_mask    (alu_mask),
    .alu_gnt     (alu_gnt),
    .sw_req      (sw_req),
    .sw_op       (sw_op),
    .sw_mask     (sw_mask),
    .sw_data     (sw_data),
    .sw_gnt      (sw_gnt),
    .irq_save    (irq_save),
    .irq_restore (irq_restore),
    .irq_done    (irq_done),
    .flags       (flags),
    .stk_full    (stk_full),
    .stk_empty   (stk_empty),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic swOp(input string name, input logic [1:0] op, input logic [15:0] mask,
                      input logic [15:0] data, input logic [15:0] expFlags);
    exp_t e;
    e = '{name, 3'b010, expFlags, 1'b0, 1'b0, 1'b0};
    sbQ.push_back(e);
    sw_req = 1'b1; sw_op = op; sw_mask = mask; sw_data = data;
    tick();
    sw_req = 1'b0;
  endtask

  task automatic aluOp(input string name, input logic [3:0] f, input logic [3:0] m,
                       input logic [15:0] expFlags);
    exp_t e;
    e = '{name, 3'b100, expFlags, 1'b0, 1'b0, 1'b0};
    sbQ.push_back(e);
    alu_req = 1'b1; alu_flags = f; alu_mask = m;
    tick();
    alu_req = 1'b0;
  endtask

  task automatic irqOp(input string name, input logic isSave, input logic [15:0] expFlags,
                       input logic eFull, input logic eEmpty, input logic eErr);
    exp_t e;
    e = '{name, 3'b001, expFlags, eFull, eEmpty, eErr};
    sbQ.push_back(e);
    if (isSave) irq_save = 1'b1;
    else        irq_restore = 1'b1;
    tick();
    irq_save = 1'b0; irq_restore = 1'b0;
    tick();
    tick();
  endtask

  // Monitor: grant events check the updated flags one cycle later,
  // irq_done events check flags and stack status in the same cycle.
  initial begin : monitor
    exp_t       pend;
    exp_t       e;
    logic       pendValid;
    logic [2:0] evt;
    pendValid = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_b !== 1'b1) begin
        pendValid = 1'b0;
      end else begin
        if (pendValid) begin
          checkOutput({pend.name, ".flags"}, 32'(flags), 32'(pend.flags));
          pendValid = 1'b0;
        end
        evt = {alu_gnt, sw_gnt, irq_done};
        if (evt != 3'b000) begin
          if (sbQ.size() == 0) begin
            checkOutput("unexpectedEvent", 32'(evt), 32'd0);
          end else begin
            e = sbQ.pop_front();
            checkOutput({e.name, ".evt"}, 32'(evt), 32'(e.evt));
            if (e.evt == 3'b001) begin
              checkOutput({e.name, ".flags"}, 32'(flags), 32'(e.flags));
              checkOutput({e.name, ".full"}, 32'(stk_full), 32'(e.full));
              checkOutput({e.name, ".empty"}, 32'(stk_empty), 32'(e.empty));
              checkOutput({e.name, ".err"}, 32'(err), 32'(e.err));
            end else begin
              pend = e;
              pendValid = 1'b1;
            end
          end
        end
      end
    end
  end

  task automatic applyStimulus();
    exp_t e;
    // Reset state
    rst_b = 1'b0;
    alu_req = 1'b0; alu_flags = '0; alu_mask = '0;
    sw_req = 1'b0; sw_op = '0; sw_mask = '0; sw_data = '0;
    irq_save = 1'b0; irq_restore = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst.flags", 32'(flags), 32'h0);
    checkOutput("rst.empty", 32'(stk_empty), 32'd1);
    checkOutput("rst.full", 32'(stk_full), 32'd0);
    checkOutput("rst.err", 32'(err), 32'd0);
    checkOutput("rst.gnts", 32'({alu_gnt, sw_gnt, irq_done}), 32'd0);
    @(posedge clk);
    #1 rst_b = 1'b1;
    tick();

    // Software ops and ALU masking
    swOp("loadIE", 2'b10, 16'hFFFF, 16'h0010, 16'h0010);
    aluOp("aluMask", 4'b1111, 4'b0101, 16'h0015);
    swOp("clrLow", 2'b01, 16'h000F, 16'h0000, 16'h0010);

    // Contention: software wins, ALU is serviced the following cycle
    e = '{"contSw", 3'b010, 16'h0014, 1'b0, 1'b0, 1'b0};
    sbQ.push_back(e);
    e = '{"contAlu", 3'b100, 16'h001D, 1'b0, 1'b0, 1'b0};
    sbQ.push_back(e);
    sw_req = 1'b1; sw_op = 2'b00; sw_mask = 16'h0004;
    alu_req = 1'b1; alu_flags = 4'b1001; alu_mask = 4'b1011;
    tick();
    sw_req = 1'b0;
    tick();
    alu_req = 1'b0;

    swOp("loadAll", 2'b10, 16'hFFFF, 16'hFFFF, 16'h001F);
    swOp("tglRsv", 2'b11, 16'h00FF, 16'h0000, 16'h0000);
    swOp("tglLow", 2'b11, 16'h0005, 16'h0000, 16'h0005);

    // Save then restore
    swOp("load13", 2'b10, 16'hFFFF, 16'h0013, 16'h0013);
    irqOp("save1", 1'b1, 16'h0003, 1'b0, 1'b0, 1'b0);
    aluOp("aluZero", 4'b0000, 4'b1111, 16'h0000);
    irqOp("restore1", 1'b0, 16'h0013, 1'b0, 1'b1, 1'b0);

    // Overflow: fill the stack then push once more
    irqOp("ovf1", 1'b1, 16'h0003, 1'b0, 1'b0, 1'b0);
    irqOp("ovf2", 1'b1, 16'h0003, 1'b0, 1'b0, 1'b0);
    irqOp("ovf3", 1'b1, 16'h0003, 1'b0, 1'b0, 1'b0);
    irqOp("ovf4", 1'b1, 16'h0003, 1'b1, 1'b0, 1'b0);
    swOp("setIE", 2'b00, 16'h0010, 16'h0000, 16'h0013);
    irqOp("ovf5", 1'b1, 16'h0003, 1'b1, 1'b0, 1'b1);
    irqOp("popAfterOvf", 1'b0, 16'h0003, 1'b0, 1'b0, 1'b1);

    // Reset while in SAVE_CLR
    swOp("loadMid", 2'b10, 16'hFFFF, 16'h0013, 16'h0013);
    irq_save = 1'b1;
    tick();
    irq_save = 1'b0;
    rst_b = 1'b0;
    tick();
    @(negedge clk);
    checkOutput("midRst.flags", 32'(flags), 32'h0);
    checkOutput("midRst.done", 32'(irq_done), 32'd0);
    checkOutput("midRst.empty", 32'(stk_empty), 32'd1);
    checkOutput("midRst.err", 32'(err), 32'd0);
    rst_b = 1'b1;
    tick();
    aluOp("postRstAlu", 4'b0011, 4'b0011, 16'h0003);

    // Underflow after reset
    irqOp("udf", 1'b0, 16'h0003, 1'b0, 1'b1, 1'b1);

    repeat (3) tick();
    checkOutput("sbDrained", 32'(sbQ.size()), 32'd0);
  endtask

  initial begin
    applyStimulus();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/flags_ctrl.md
Name: flags_ctrl

Overview:
- Owns and sequences the 16-bit processor status (FLAGS) register.
- Arbitrates three update sources: ALU condition results, software flag instructions (set/clear/load/toggle) and interrupt save/restore.
- Save/restore goes through a small LIFO shadow stack so interrupts can nest.
- Sits between the control unit / ALU and the flags storage; the flags value it drives is the architectural FLAGS seen by the branch unit.

Parameters:
- FLAG_W, 16, width of the flags register.
- STACK_DEPTH, 4, number of shadow-stack entries (power of two, at least 2).

Ports:
- clk  in  1  system clock, rising edge.
- rst_b  in  1  reset, synchronous, active-low.
- alu_req  in  1  ALU requests a condition-code update.
- alu_flags  in  4  new {V,C,N,Z} values.
- alu_mask  in  4  per-bit write enable for {V,C,N,Z}.
- alu_gnt  out  1  ALU update applied this cycle.
- sw_req  in  1  software flag-instruction request.
- sw_op  in  2  00 SET, 01 CLEAR, 10 LOAD, 11 TOGGLE.
- sw_mask  in  FLAG_W  bits affected.
- sw_data  in  FLAG_W  data for LOAD.
- sw_gnt  out  1  software op applied this cycle.
- irq_save  in  1  push flags and clear IE.
- irq_restore  in  1  pop flags.
- irq_done  out  1  one-cycle pulse when a save or restore completes.
- flags  out  FLAG_W  current register value.
- stk_full  out  1  stack holds STACK_DEPTH entries.
- stk_empty  out  1  stack holds 0 entries.
- err  out  1  sticky overflow/underflow error; cleared only by reset.

Behaviour:
- Bit map: 0 Z, 1 N, 2 C, 3 V, 4 IE. Bits FLAG_W-1..5 are reserved: always 0, writes ignored.
- Reset (rst_b=0 at a clk edge):
  - flags=0, stack pointer=0, err=0, state=IDLE.
  - All grants and irq_done are 0.
  - A reset mid-SAVE or mid-RESTORE aborts the operation; stack contents become don't-care.
- FSM states: IDLE, SAVE_CLR, RESTORE_LD.
- IDLE arbitration, fixed priority irq_restore > irq_save > sw_req > alu_req. Exactly one source acts per cycle:
  - irq_restore:
    - Stack non-empty: read top entry, go to RESTORE_LD.
    - Stack empty: set err, flags unchanged, irq_done pulses next cycle, stay in IDLE.
  - irq_save:
    - Stack not full: push flags at this edge, pointer+1, go to SAVE_CLR.
    - Stack full: set err, no push, still clear IE, irq_done pulses.
  - sw_req, with flags' as the next value:
    - SET: flags' = flags | mask.
    - CLEAR: flags' = flags & ~mask.
    - LOAD: flags' = (flags & ~mask) | (data & mask).
    - TOGGLE: flags' = flags ^ mask.
    - sw_gnt=1 combinationally in the same cycle; the update is visible on flags the next cycle.
  - alu_req: flags[3:0]' = (flags[3:0] & ~alu_mask) | (alu_flags & alu_mask); alu_gnt=1 same cycle.
- SAVE_CLR: clear IE; irq_done=1 registered in the following cycle; return to IDLE. Total save latency is 2 cycles.
- RESTORE_LD: flags' = popped entry with reserved bits masked; pointer-1; irq_done=1 next cycle; return to IDLE.
- While in SAVE_CLR or RESTORE_LD, all grants are 0. Losing or stalled requesters must hold req until gnt. A grant is never given without a req.
- Status outputs:
  - stk_full = (ptr==STACK_DEPTH); stk_empty = (ptr==0).
  - Pointer width is clog2(STACK_DEPTH)+1; it never wraps.
- Simultaneous irq_save and irq_restore: restore wins; the save must be re-presented.
- A request held across a grant cycle is serviced again. Requesters must deassert req after gnt for a single update.

Decomposition:
- Package flags_pkg holds:
  - bit index constants Z_B, N_B, C_B, V_B, IE_B and RESERVED_MASK;
  - sw_op encodings OP_SET, OP_CLR, OP_LOAD, OP_TGL;
  - the FSM state enum.
- Sub-module flags_stack: a LIFO of STACK_DEPTH x FLAG_W with push, pop, top, full, empty and synchronous active-low reset.
- The flags register itself is built from the team's ffd cells with enable driven by the arbiter.

Test Plan:
- Reset: hold rst_b=0 for 2 cycles -> flags=0x0000, stk_empty=1, stk_full=0, err=0, all gnt=0.
- ALU mask: flags=0x0010, alu_req with alu_flags=4'b1111, alu_mask=4'b0101 -> alu_gnt=1, next flags=0x0015.
- Contention: sw_req SET mask=0x0004 together with alu_req -> sw_gnt=1, alu_gnt=0. Next cycle alu_gnt=1. LOAD mask=0xFFFF data=0xFFFF gives 0x001F.
- Save/restore: flags=0x0013, irq_save:
  - SAVE_CLR -> flags=0x0003, irq_done one cycle later.
  - ALU sets flags to 0x0000, then irq_restore -> flags=0x0013 after 2 cycles, stk_empty=1.
- Overflow/underflow: 5 saves with depth 4 -> stk_full after the 4th, err=1 after the 5th, IE still cleared. Restore on empty after reset -> err=1, flags unchanged.
- Reset mid-op: rst_b=0 in the cycle the FSM is in SAVE_CLR -> next cycle flags=0, state IDLE, irq_done=0, stk_empty=1.
